fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Drain side for the team's synchronous FIFO. Drives the FIFO read port (r_en/empty/data_out, data valid one cycle after r_en) and presents the words as a valid/ready stream with packet framing. An internal 2-entry skid buffer absorbs the FIFO's 1-cycle read latency, so the block sustains one word per clock with no bubbles under continuous m_ready.

Parameters:
DATA_WIDTH, 8, word width; matches the FIFO's DATA_WIDTH.
PKT_LEN, 4, beats per packet; m_last marks every PKT_LEN-th beat; legal range 1..255.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
fifo_empty  input  1  FIFO empty flag.
fifo_rdata  input  DATA_WIDTH  FIFO data_out; valid the cycle after fifo_rd_en.
fifo_rd_en  output  1  FIFO read enable (combinational).
m_valid  output  1  stream word valid.
m_data  output  DATA_WIDTH  stream word (buffer head).
m_last  output  1  final beat of a packet; qualified by m_valid.
m_ready  input  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous): occupancy=0, inflight=0, beat_cnt=0, buffer contents=0.
- Reset values of outputs: m_valid=0, m_data=0, m_last=0, fifo_rd_en=0.
- fifo_rd_en is forced to 0 while rst_n is low.
- State:
  - occ: 0..2, words held in the skid buffer.
  - inflight: 1 if fifo_rd_en was high last cycle.
  - beat_cnt: 0..PKT_LEN-1, width $clog2(PKT_LEN+1).
- pop = m_valid & m_ready.
- fifo_rd_en = !fifo_empty & ((occ + inflight - pop) <= 1). This keeps occ + inflight <= 2 at all times, so no overflow and no data loss.
- Capture: if inflight==1, fifo_rdata is written into the buffer at the tail in that cycle. Capture and pop in the same cycle: occ stays unchanged, head advances, and the new word lands in order.
- m_valid = (occ != 0). m_data is the head entry.
  - m_data and m_last are held stable while m_valid & !m_ready.
- m_last = m_valid & (beat_cnt == PKT_LEN-1).
  - On pop: beat_cnt wraps to 0 if it was PKT_LEN-1, otherwise increments.
  - PKT_LEN=1 means m_last = m_valid.
- Throughput: with the FIFO non-empty and m_ready held high, the first m_valid is 2 cycles after fifo_empty deasserts (rd_en cycle, capture cycle, output next). After that, 1 word per cycle.
- Backpressure: with m_ready low, at most 2 words accumulate, then fifo_rd_en drops. After m_ready rises, words drain back-to-back.
- FIFO empties mid-stream: fifo_rd_en drops; buffered words still drain; m_valid deasserts once occ reaches 0; beat_cnt is preserved across gaps.
- Reset mid-operation: buffered and in-flight words are discarded and beat_cnt clears. The FIFO, on its own reset, restarts in sync.
- Head/tail pointers are 1 bit each and wrap naturally.
- occ arithmetic uses 2-bit unsigned.
- The sum occ + inflight - pop is evaluated in 3 bits so no underflow occurs (pop implies occ >= 1).

Decomposition:
- Shared package: none required. Hold DATA_WIDTH consistent with the FIFO instance at integration.
- One natural sub-module: skid_buffer2. It is the 2-entry register buffer with push/pop/occ, and holds contents stable under stall.
- fifo_stream_reader holds:
  - the rd_en credit logic,
  - the inflight flag,
  - the beat counter.

Test Plan:
1. Streaming: preload FIFO with 0x10..0x17, m_ready=1, PKT_LEN=4. Expect m_data 0x10..0x17 on 8 consecutive cycles, m_last on 0x13 and 0x17, and fifo_rd_en high for exactly 8 cycles.
2. Backpressure: FIFO holds 0xA0..0xA5, m_ready=0 for 10 cycles. Expect exactly 2 fifo_rd_en pulses and m_data held at 0xA0. Then m_ready=1: output 0xA0..0xA5 in order, no gaps, no duplicates.
3. Random m_ready (50%) over 200 words with random FIFO writes. Scoreboard checks:
   - the output sequence equals the write sequence;
   - no word is dropped or duplicated;
   - m_data is stable while stalled;
   - m_last occurs every 4th accepted beat.
4. Underflow gap: write 0x01, 0x02, wait 5 cycles, write 0x03, 0x04 with m_ready=1. Expect m_valid to deassert during the gap, with no rd_en while fifo_empty. m_last is on 0x04 (beat 4), proving beat_cnt persists across gaps.
5. Async reset mid-stream: assert rst_n low between clock edges while occ=2. Expect m_valid, m_last, m_data and fifo_rd_en at 0 immediately, before the next edge. After release with an empty FIFO, expect m_valid=0.
6. PKT_LEN=1 instance: stream 3 words. Expect m_last high on every valid beat.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_pkg
//
// Shared types and helpers for the FIFO drain-side stream reader.
//
// Contents:
//   occ_t       - skid-buffer occupancy (0..2), 2-bit unsigned
//   SKID_DEPTH  - number of entries in the skid buffer
//   credit_ok() - decides whether one more FIFO read may be launched
// -----------------------------------------------------------------------------
package fifo_stream_reader_pkg;

  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // A read may be launched when the words already committed to the buffer
  // (held + in flight, minus the one leaving this cycle) leave room for one
  // more. Evaluated in 3 bits: pop implies occ >= 1, so the subtraction never
  // wraps, and the sum never exceeds 3.
  function automatic logic credit_ok(input occ_t occ,
                                     input logic inflight,
                                     input logic pop);
    logic [2:0] committed;
    committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    return (committed <= 3'd1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader_if
//
// Valid/ready stream with packet framing.
//
// Handshake: a beat transfers on a rising clock edge where m_valid and m_ready
// are both high. Once m_valid is raised it stays high, and m_data / m_last
// stay unchanged, until that beat transfers. m_ready may change freely and is
// allowed to depend combinationally on m_valid. m_last is only meaningful
// while m_valid is high.
//
// Signals:
//   m_valid  - stream word valid               (master -> slave)
//   m_data   - stream word, DATA_WIDTH bits    (master -> slave)
//   m_last   - final beat of a packet          (master -> slave)
//   m_ready  - downstream accept               (slave -> master)
// -----------------------------------------------------------------------------
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/fifo_stream_reader_skid_buffer2.sv
// -----------------------------------------------------------------------------
// skid_buffer2
//
// Two-entry register buffer used to absorb the FIFO's one-cycle read latency.
// Entries are written at the tail and read from the head; both pointers are a
// single bit and wrap naturally. Contents are never moved, so the head word is
// stable for as long as it is not popped.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset; clears pointers, occupancy and
//                contents
//   push       - write push_data at the tail this cycle
//   push_data  - word to write
//   pop        - retire the head entry this cycle (caller guarantees occ != 0)
//   occ        - number of words held (0..2)
//   head_data  - current head entry
//
// The caller guarantees push is never asserted while the buffer is full
// unless pop is asserted in the same cycle.
// -----------------------------------------------------------------------------
module skid_buffer2
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output occ_t                  occ,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic                  head;
  logic                  tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      // Simultaneous push and pop leaves occupancy unchanged; the new word
      // lands behind the surviving entry, so ordering is preserved.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Drain side for the synchronous FIFO. Issues FIFO reads, captures the data
// that returns one cycle later into a two-entry skid buffer, and presents the
// words as a valid/ready stream with packet framing. With the FIFO non-empty
// and m_ready held high it delivers one word per clock.
//
// Parameters:
//   DATA_WIDTH - word width; must match the FIFO instance
//   PKT_LEN    - beats per packet (1..255); m_last marks every PKT_LEN-th beat
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   fifo_empty  - FIFO empty flag
//   fifo_rdata  - FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en  - FIFO read enable (combinational, low while in reset)
//   m           - stream master (m_valid, m_data, m_last, m_ready)
// -----------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  fifo_rd_en,
  fifo_stream_reader_if.master  m
);

  localparam int                CNT_W     = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(PKT_LEN - 1);

  occ_t                  occ;
  logic                  inflight;
  logic                  pop;
  logic [CNT_W-1:0]      beat_cnt;
  logic [DATA_WIDTH-1:0] head_data;

  assign pop = m.m_valid & m.m_ready;

  // Credit check: held words plus the read already in flight, less the word
  // leaving now, must leave room for the word this read will return. This
  // keeps occ + inflight <= 2, so the buffer can never overflow. Gated by
  // rst_n so the FIFO sees no read while this block is held in reset.
  assign fifo_rd_en = rst_n & ~fifo_empty & credit_ok(occ, inflight, pop);

  // A read issued this cycle returns data next cycle; this flag marks that
  // next cycle as a capture cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  skid_buffer2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (pop),
    .occ       (occ),
    .head_data (head_data)
  );

  // Beat position within the current packet. Only accepted beats advance it,
  // so it survives stalls and FIFO underflow gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  assign m.m_valid = (occ != 2'd0);
  assign m.m_data  = head_data;
  assign m.m_last  = m.m_valid & (beat_cnt == LAST_BEAT);

endmodule
